// File: rtl/segment_scanner_pkg.sv
// Shared definitions for the piecewise-linear segmentation controller.
//   DW         : index/data width of every index, deviation and mean value
//   state_t    : scanner FSM states
//   seg_rec_t  : one emitted segment record {start, end, dev, mean, last}
//   make_rec   : builds a record; 'last' is set when the record ends at n
package segment_scanner_pkg;

  localparam int unsigned DW = 32;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_LOW,
    WAIT_DONE,
    EVAL,
    EMIT,
    FINISH
  } state_t;

  typedef struct packed {
    logic [DW-1:0] start_idx;
    logic [DW-1:0] end_idx;
    logic [DW-1:0] dev;
    logic [DW-1:0] mean;
    logic          last;
  } seg_rec_t;

  function automatic seg_rec_t make_rec(input logic [DW-1:0] s,
                                        input logic [DW-1:0] e,
                                        input logic [DW-1:0] d,
                                        input logic [DW-1:0] m,
                                        input logic [DW-1:0] n);
    seg_rec_t r;
    r.start_idx = s;
    r.end_idx   = e;
    r.dev       = d;
    r.mean      = m;
    r.last      = (e == n);
    return r;
  endfunction

endpackage

// File: rtl/segment_scanner_out.sv
// Single-entry valid/ready holding register for segment records.
//   Clk, Rst : clock, synchronous active-low reset
//   load     : capture rec_in and raise valid (wins over a same-cycle accept)
//   rec_in   : record to capture
//   ready    : consumer accepts the held record when valid
//   valid    : a record is held
//   rec      : held record, stable while valid and not accepted
module segment_out_reg
  import segment_scanner_pkg::*;
(
  input  logic     Clk,
  input  logic     Rst,
  input  logic     load,
  input  seg_rec_t rec_in,
  input  logic     ready,
  output logic     valid,
  output seg_rec_t rec
);

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      valid <= 1'b0;
      rec   <= '0;
    end else if (load) begin
      valid <= 1'b1;
      rec   <= rec_in;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/segment_scanner.sv
// Segmentation controller driving a linear-fit/deviation engine. Grows a fit
// window from the segment start until the deviation exceeds the threshold or
// MAX_LEN is reached, then emits one segment record and resumes at its end.
//   Clk, Rst                 : clock, synchronous active-low reset
//   go, n_samples, threshold : scan request; N and T latched on go in IDLE
//   busy, scan_done          : scan in progress / one-cycle completion pulse
//   fit_si, fit_ei, fit_start: window [si, ei) and start strobe to the engine
//   fit_done, fit_deviation, fit_mean : engine status and results
//   seg_valid, seg_ready     : record handshake
//   seg_start, seg_end, seg_dev, seg_mean, seg_last : record fields
module segment_scanner
  import segment_scanner_pkg::*;
#(
  parameter int unsigned MIN_LEN = 2,
  parameter int unsigned MAX_LEN = 64
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          go,
  input  logic [DW-1:0] n_samples,
  input  logic [DW-1:0] threshold,
  output logic          busy,
  output logic          scan_done,
  output logic [DW-1:0] fit_si,
  output logic [DW-1:0] fit_ei,
  output logic          fit_start,
  input  logic          fit_done,
  input  logic [DW-1:0] fit_deviation,
  input  logic [DW-1:0] fit_mean,
  output logic          seg_valid,
  input  logic          seg_ready,
  output logic [DW-1:0] seg_start,
  output logic [DW-1:0] seg_end,
  output logic [DW-1:0] seg_dev,
  output logic [DW-1:0] seg_mean,
  output logic          seg_last
);

  localparam logic [DW-1:0] MIN_W = DW'(MIN_LEN);
  localparam logic [DW-1:0] MAX_W = DW'(MAX_LEN);
  localparam logic [DW-1:0] ONE   = DW'(1);

  state_t        state, state_next;
  logic [DW-1:0] n_reg, t_reg, si, ei, best_dev, best_mean;
  logic [DW-1:0] si_d, ei_d;
  logic          latch, best_we, rec_load, seg_fire, over;
  seg_rec_t      rec_d, rec_q;

  assign seg_fire = seg_valid && seg_ready;
  assign over     = fit_deviation > t_reg;

  always_ff @(posedge Clk) begin
    if (!Rst) state <= IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      n_reg     <= '0;
      t_reg     <= '0;
      si        <= '0;
      ei        <= '0;
      best_dev  <= '0;
      best_mean <= '0;
    end else begin
      if (latch) begin
        n_reg <= n_samples;
        t_reg <= threshold;
      end
      si <= si_d;
      ei <= ei_d;
      if (best_we) begin
        best_dev  <= fit_deviation;
        best_mean <= fit_mean;
      end
    end
  end

  always_comb begin
    state_next = state;
    si_d       = si;
    ei_d       = ei;
    latch      = 1'b0;
    best_we    = 1'b0;
    rec_load   = 1'b0;
    rec_d      = '0;
    case (state)
      IDLE: if (go) begin
        latch = 1'b1;
        si_d  = '0;
        if (n_samples == '0) begin
          state_next = FINISH;
        end else if (n_samples < MIN_W) begin
          rec_load   = 1'b1;
          rec_d      = make_rec('0, n_samples, '0, '0, n_samples);
          state_next = EMIT;
        end else begin
          ei_d       = MIN_W;
          state_next = LAUNCH;
        end
      end
      LAUNCH:    state_next = WAIT_LOW;
      WAIT_LOW:  state_next = WAIT_DONE;
      WAIT_DONE: if (fit_done) state_next = EVAL;
      EVAL: begin
        // Split case and the two "record [si, ei)" cases share one load path;
        // only the split reports the previous window with the stored best.
        if (over && ei > si + MIN_W)
          rec_d = make_rec(si, ei - ONE, best_dev, best_mean, n_reg);
        else
          rec_d = make_rec(si, ei, fit_deviation, fit_mean, n_reg);
        best_we = !over;
        if (over || ei == n_reg || ei - si == MAX_W) begin
          rec_load   = 1'b1;
          state_next = EMIT;
        end else begin
          ei_d       = ei + ONE;
          state_next = LAUNCH;
        end
      end
      EMIT: if (seg_fire) begin
        si_d = rec_q.end_idx;
        if (rec_q.end_idx == n_reg) begin
          state_next = FINISH;
        end else if (n_reg - rec_q.end_idx < MIN_W) begin
          // Tail record: reloaded in place, valid stays high, no fit.
          rec_load = 1'b1;
          rec_d    = make_rec(rec_q.end_idx, n_reg, '0, '0, n_reg);
        end else begin
          ei_d       = rec_q.end_idx + MIN_W;
          state_next = LAUNCH;
        end
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE) && (state != FINISH);
    scan_done = (state == FINISH);
    fit_start = (state == LAUNCH);
  end

  assign fit_si = si;
  assign fit_ei = ei;

  segment_out_reg u_out (
    .Clk    (Clk),
    .Rst    (Rst),
    .load   (rec_load),
    .rec_in (rec_d),
    .ready  (seg_ready),
    .valid  (seg_valid),
    .rec    (rec_q)
  );

  assign seg_start = rec_q.start_idx;
  assign seg_end   = rec_q.end_idx;
  assign seg_dev   = rec_q.dev;
  assign seg_mean  = rec_q.mean;
  assign seg_last  = rec_q.last;

endmodule

// File: tb/tb_segment_scanner.sv
// Self-checking bench for segment_scanner: behavioural engine model plus a
// reference segmentation model computing expected launches and records.
module tb_segment_scanner;

  localparam int unsigned MIN_LEN = 3;
  localparam int unsigned MAX_LEN = 8;

  logic        Clk = 1'b0;
  logic        Rst, go, busy, scan_done, fit_start, fit_done;
  logic        seg_valid, seg_ready, seg_last;
  logic [31:0] n_samples, threshold, fit_si, fit_ei, fit_deviation, fit_mean;
  logic [31:0] seg_start, seg_end, seg_dev, seg_mean;

  always #5 Clk = ~Clk;

  segment_scanner #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
    .Clk(Clk), .Rst(Rst), .go(go), .n_samples(n_samples), .threshold(threshold),
    .busy(busy), .scan_done(scan_done), .fit_si(fit_si), .fit_ei(fit_ei),
    .fit_start(fit_start), .fit_done(fit_done), .fit_deviation(fit_deviation),
    .fit_mean(fit_mean), .seg_valid(seg_valid), .seg_ready(seg_ready),
    .seg_start(seg_start), .seg_end(seg_end), .seg_dev(seg_dev),
    .seg_mean(seg_mean), .seg_last(seg_last)
  );

  typedef struct packed {
    logic [31:0] s, e, d, m;
    logic        l;
  } rec_t;

  rec_t        exp_recs[$];
  logic [63:0] exp_launch[$];
  rec_t        cur, held, er;
  int unsigned n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---- data model: deviation/mean of window [s, e) ----
  int unsigned dev_mode = 0, dev_bp = 0, dev_seed = 0;

  function automatic logic [31:0] dev_f(input logic [31:0] s, input logic [31:0] e);
    logic [31:0] h;
    case (dev_mode)
      0: return 32'd0;
      1: return (e > dev_bp) ? 32'd100 : 32'd10;
      default: begin
        h = (s * 32'h9E3779B1) ^ (e * 32'h85EBCA6B) ^ dev_seed;
        h = h ^ (h >> 13);
        return {24'd0, h[7:0]};
      end
    endcase
  endfunction

  function automatic logic [31:0] mean_f(input logic [31:0] s, input logic [31:0] e);
    return (s << 16) + e;
  endfunction

  // Each segment from si ends at the largest e in [si+MIN, min(N, si+MAX)]
  // whose windows [si, si+MIN..e) all pass; a failing minimum window is kept.
  function automatic void build_model(input logic [31:0] n, input logic [31:0] t);
    logic [31:0] si, k, cap, e;
    rec_t r;
    exp_recs.delete();
    exp_launch.delete();
    si = 0;
    while (si < n) begin
      if (n - si < MIN_LEN) begin
        r.s = si; r.e = n; r.d = 0; r.m = 0; r.l = 1'b1;
        exp_recs.push_back(r);
        si = n;
      end else begin
        cap = (n - si > MAX_LEN) ? si + MAX_LEN : n;
        k = si + MIN_LEN;
        exp_launch.push_back({si, k});
        while (dev_f(si, k) <= t && k < cap) begin
          k++;
          exp_launch.push_back({si, k});
        end
        e = (dev_f(si, k) > t && k > si + MIN_LEN) ? k - 1 : k;
        r.s = si; r.e = e; r.d = dev_f(si, e); r.m = mean_f(si, e); r.l = (e == n);
        exp_recs.push_back(r);
        si = e;
      end
    end
  endfunction

  // ---- monitor, engine model and consumer (all act on the falling edge) ----
  logic        mon_en = 1'b0;
  logic        launch_due = 1'b0, tail_due = 1'b0, done_due = 1'b0, held_valid = 1'b0;
  int unsigned ready_mode = 1, stall_cnt = 0, n_cur = 0;
  int unsigned eng_stage = 0, eng_cnt = 0, lat_min = 1, lat_max = 4;
  logic [31:0] eng_si, eng_ei;
  logic [63:0] la;

  always @(negedge Clk) begin
    if (mon_en) begin
      cur = {seg_start, seg_end, seg_dev, seg_mean, seg_last};
      case (eng_stage)
        1: eng_stage = 2;
        2: begin fit_done = 1'b0; eng_cnt = $urandom_range(lat_max, lat_min); eng_stage = 3; end
        3: begin
          eng_cnt--;
          if (eng_cnt == 0) begin
            fit_done = 1'b1;
            fit_deviation = dev_f(eng_si, eng_ei);
            fit_mean = mean_f(eng_si, eng_ei);
            eng_stage = 0;
          end
        end
        default: ;
      endcase
      if (fit_start) begin
        check("launch_expected", 64'(exp_launch.size() != 0), 64'd1);
        if (exp_launch.size() != 0) begin
          la = exp_launch.pop_front();
          check("fit_window", {fit_si, fit_ei}, la);
        end
        eng_si = fit_si; eng_ei = fit_ei; eng_stage = 1;
      end
      if (launch_due) check("launch_after_hs", 64'(fit_start), 64'd1);
      if (tail_due)   check("tail_after_hs", 64'(seg_valid), 64'd1);
      if (scan_done || done_due) check("scan_done", 64'(scan_done), 64'(done_due));
      launch_due = 1'b0; tail_due = 1'b0; done_due = 1'b0;
      if (held_valid) begin
        check("hold_valid", 64'(seg_valid), 64'd1);
        check("hold_start", 64'(seg_start), 64'(held.s));
        check("hold_end", 64'(seg_end), 64'(held.e));
        check("hold_dev", 64'(seg_dev), 64'(held.d));
        check("hold_mean", 64'(seg_mean), 64'(held.m));
        check("stall_no_launch", 64'(fit_start), 64'd0);
      end
      case (ready_mode)
        0: seg_ready = ($urandom_range(0, 3) != 0);
        2: if (seg_valid && stall_cnt < 20) begin seg_ready = 1'b0; stall_cnt++; end
           else seg_ready = 1'b1;
        default: seg_ready = 1'b1;
      endcase
      held_valid = seg_valid && !seg_ready;
      held = cur;
      if (seg_valid && seg_ready) begin
        check("record_expected", 64'(exp_recs.size() != 0), 64'd1);
        if (exp_recs.size() != 0) begin
          er = exp_recs.pop_front();
          check("seg_start", 64'(cur.s), 64'(er.s));
          check("seg_end", 64'(cur.e), 64'(er.e));
          check("seg_dev", 64'(cur.d), 64'(er.d));
          check("seg_mean", 64'(cur.m), 64'(er.m));
          check("seg_last", 64'(cur.l), 64'(er.l));
          if (er.l) done_due = 1'b1;
          else if (n_cur - er.e >= MIN_LEN) launch_due = 1'b1;
          else tail_due = 1'b1;
        end
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_scan_done"}, 64'(scan_done), 64'd0);
    check({tag, "_fit_start"}, 64'(fit_start), 64'd0);
    check({tag, "_fit_si"}, 64'(fit_si), 64'd0);
    check({tag, "_fit_ei"}, 64'(fit_ei), 64'd0);
    check({tag, "_seg_valid"}, 64'(seg_valid), 64'd0);
    check({tag, "_seg_start"}, 64'(seg_start), 64'd0);
    check({tag, "_seg_end"}, 64'(seg_end), 64'd0);
    check({tag, "_seg_dev"}, 64'(seg_dev), 64'd0);
    check({tag, "_seg_mean"}, 64'(seg_mean), 64'd0);
    check({tag, "_seg_last"}, 64'(seg_last), 64'd0);
  endtask

  task automatic run_scan(input logic [31:0] n, input logic [31:0] t, input int unsigned rmode);
    int unsigned cyc;
    build_model(n, t);
    n_cur = n; ready_mode = rmode; stall_cnt = 0;
    @(negedge Clk); #1;
    fit_done = 1'b0;                       // stray low done while idle
    @(negedge Clk); #1;
    check("idle_busy", 64'(busy), 64'd0);
    fit_done = 1'b1;
    go = 1'b1; n_samples = n; threshold = t;
    done_due = (n == 0);
    @(negedge Clk); #1;
    go = 1'b0; n_samples = $urandom; threshold = $urandom;
    check("busy_rise", 64'(busy), 64'(n != 0));
    check("fit_start_rise", 64'(fit_start), 64'(n >= MIN_LEN));
    check("tail_rise", 64'(seg_valid), 64'(n != 0 && n < MIN_LEN));
    cyc = 0;
    while (!scan_done && cyc < 5000) begin
      @(negedge Clk); #1;
      cyc++;
      // go while busy must be ignored
      if (cyc == 5 && busy) begin go = 1'b1; n_samples = 32'd1; end
      else go = 1'b0;
    end
    go = 1'b0;
    check("scan_completes", 64'(scan_done), 64'd1);
    check("records_left", 64'(exp_recs.size()), 64'd0);
    check("launches_left", 64'(exp_launch.size()), 64'd0);
    @(negedge Clk); #1;
    check("done_pulse_width", 64'(scan_done), 64'd0);
    check("busy_after_done", 64'(busy), 64'd0);
  endtask

  initial begin
    Rst = 1'b0; go = 1'b0; n_samples = '0; threshold = '0; fit_done = 1'b1;
    fit_deviation = '0; fit_mean = '0; seg_ready = 1'b0;
    repeat (3) @(negedge Clk);
    #1;
    check_reset_vals("reset");
    Rst = 1'b1; mon_en = 1'b1;

    dev_mode = 0;               run_scan(32'd10, 32'd0, 1);
    dev_mode = 1; dev_bp = 6;   run_scan(32'd12, 32'd50, 1);
    dev_mode = 0;               run_scan(32'd9, 32'd0, 1);
    run_scan(32'd0, 32'd0, 1);
    run_scan(32'd1, 32'd0, 1);
    run_scan(32'd2, 32'd0, 0);
    run_scan(32'd3, 32'd0, 0);
    dev_mode = 2; dev_seed = $urandom; run_scan(32'd30, 32'd128, 2);

    // reset while the engine is mid-fit
    dev_mode = 0; build_model(32'd20, 32'd0); n_cur = 20; ready_mode = 1;
    lat_min = 12; lat_max = 12;
    @(negedge Clk); #1;
    go = 1'b1; n_samples = 32'd20; threshold = '0;
    @(negedge Clk); #1;
    go = 1'b0;
    check("mid_launch", 64'(fit_start), 64'd1);
    repeat (2) @(negedge Clk);
    #1;
    Rst = 1'b0; mon_en = 1'b0;
    @(negedge Clk); #1;
    check_reset_vals("reset_mid");
    Rst = 1'b1;
    exp_recs.delete(); exp_launch.delete();
    launch_due = 1'b0; tail_due = 1'b0; done_due = 1'b0; held_valid = 1'b0;
    eng_stage = 0; fit_done = 1'b1; lat_min = 1; lat_max = 4;
    mon_en = 1'b1;
    run_scan(32'd20, 32'd0, 1);

    for (int i = 0; i < 40; i++) begin
      dev_mode = $urandom_range(0, 2);
      dev_bp = $urandom_range(0, 40);
      dev_seed = $urandom;
      run_scan($urandom_range(0, 40),
               (dev_mode == 2) ? $urandom_range(0, 255) : ((dev_mode == 1) ? 50 : 0),
               $urandom_range(0, 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule

// File: doc/segment_scanner.md
# segment_scanner

Piecewise-linear segmentation controller that sits directly downstream of the linear-fit/deviation engine (LinRegDev). It drives the engine's start/end index and start strobe, consumes its deviation and mean results, and grows a fit window from a segment start until the deviation exceeds a threshold or a maximum length is reached. It then emits one segment record on a valid/ready output and resumes at the segment's end.

## Interface
Parameters:
- MIN_LEN, 2: minimum fitted window length in samples; must be ≥ 2.
- MAX_LEN, 64: maximum segment length in samples; must be ≥ MIN_LEN.

Ports:
- Clk  in  1  clock; all logic on rising edge.
- Rst  in  1  reset, synchronous, active-low.
- go  in  1  start a scan; sampled only in IDLE.
- n_samples  in  32  total sample count, latched on go.
- threshold  in  32  unsigned deviation limit, latched on go.
- busy  out  1  high from the cycle after go until scan_done.
- scan_done  out  1  one-cycle pulse when the scan completes.
- fit_si  out  32  window start index to the engine.
- fit_ei  out  32  window end index (exclusive) to the engine.
- fit_start  out  1  one-cycle start strobe to the engine.
- fit_done  in  1  engine idle/finished flag.
- fit_deviation  in  32  engine mean-square deviation.
- fit_mean  in  32  engine mean result.
- seg_valid  out  1  segment record valid.
- seg_ready  in  1  consumer accepts the record.
- seg_start  out  32  segment first index.
- seg_end  out  32  segment end index (exclusive).
- seg_dev  out  32  accepted deviation; 0 for tail segments.
- seg_mean  out  32  accepted mean; 0 for tail segments.
- seg_last  out  1  qualifies the final segment of the scan.

## Operation
- States: IDLE, LAUNCH, WAIT_LOW, WAIT_DONE, EVAL, EMIT, FINISH.
- IDLE, go=1:
  - Latch N=n_samples and T=threshold; set si=0.
  - Go to FINISH if N=0.
  - Go to EMIT with a tail record if N<MIN_LEN.
  - Otherwise set ei=MIN_LEN and go to LAUNCH.
- LAUNCH: drive fit_si=si and fit_ei=ei, assert fit_start for exactly one cycle, then go to WAIT_LOW.
- WAIT_LOW: fit_done is ignored for this one cycle, because the engine drops done the cycle after start. Go to WAIT_DONE.
- WAIT_DONE: wait for fit_done=1, then go to EVAL. fit_si and fit_ei are held stable throughout the fit.
- EVAL:
  - If fit_deviation > T (unsigned) and ei > si+MIN_LEN: split. The record is [si, ei-1) with the stored previous dev/mean.
  - Else, if fit_deviation > T and ei = si+MIN_LEN: accept anyway. The record is [si, ei) with the current dev/mean; the minimum window is never rejected.
  - Else store dev/mean as best:
    - If ei = N or ei-si = MAX_LEN, the record is [si, ei).
    - Otherwise ei += 1 and go to LAUNCH.
- EMIT:
  - Hold seg_* stable while seg_valid=1 and seg_ready=0.
  - On the handshake, set si=seg_end.
  - If si = N, go to FINISH.
  - Else, if N-si < MIN_LEN, emit a tail record [si, N) with dev=0 and mean=0 (no fit).
  - Else set ei=si+MIN_LEN and go to LAUNCH.
- seg_last=1 on the record whose seg_end = N.
- FINISH: pulse scan_done and busy=0, then return to IDLE.
- go while busy is ignored.
- fit_done=0 observed in IDLE is ignored.
- All index arithmetic is 32-bit unsigned. ei never exceeds N; no wrap occurs for N ≤ 2^32-1.

## Timing
- Reset values: busy=0, scan_done=0, fit_start=0, fit_si=0, fit_ei=0, seg_valid=0, seg_start=0, seg_end=0, seg_dev=0, seg_mean=0, seg_last=0. State is IDLE.
- busy rises 1 cycle after go.
- fit_start rises 1 cycle after go, in LAUNCH.
- Per-window overhead is 3 cycles (LAUNCH, WAIT_LOW, EVAL) plus the engine fit time.
- seg_valid rises the cycle after EVAL decides. The record transfers on the edge where seg_valid and seg_ready are both 1.
- The next fit_start occurs the cycle after the handshake; scan_done the cycle after the final handshake.
- seg_ready held high gives no bubbles beyond those above. seg_ready low stalls indefinitely with no fit launched.
- Reset asserted mid-scan returns to reset values on the next edge:
  - seg_valid drops without handshake.
  - An in-flight engine fit is abandoned; the engine must be reset together with this block.

## Structure
- Shared package holds:
  - the state enum;
  - the 32-bit index/data width constant;
  - the segment record typedef {start, end, dev, mean, last}.
- No sub-module is required. An optional segment_out_reg (single-entry valid/ready holding register) is the natural split for the output side.

## Test plan
- Constant data, N=10, T=0, engine model returns dev=0: windows grow to ei=10. Exactly one record [0,10), seg_last=1, then scan_done.
- Engine returns dev=100 once window end >6, T=50, N=12:
  - Record [0,6) carries the dev/mean of window [0,6).
  - Next scan starts at si=6 with fit_si=6 and fit_ei=8.
- MAX_LEN=4, N=9, always dev=0: records [0,4), [4,8), then tail [8,9) with dev=0, mean=0, seg_last=1. No fit is launched for the tail.
- N=0 produces scan_done with no records. N=1 produces a single tail [0,1) without fit_start.
- seg_ready held low for 20 cycles at the first record: the record stays stable, fit_start stays 0, and the scan resumes the cycle after the handshake.
- Reset pulsed while in WAIT_DONE: all outputs return to reset values the next cycle. A following go restarts at si=0.
